// File: rtl/data_memory.sv
// data_memory: byte-addressable RV32I load/store memory with sticky fault status
module data_memory #(
    parameter int DEPTH_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] DMAddress,
    input  logic [31:0] DMDataWr,
    input  logic        DMWr,
    input  logic        DMRd,
    input  logic [2:0]  DMCtrl,
    output logic [31:0] DMDataRd,
    output logic [2:0]  DMFaultFlags,
    output logic [31:0] DMFaultAddr
);
    localparam int AW = $clog2(DEPTH_BYTES);
    logic [7:0]    mem [DEPTH_BYTES];
    logic [AW-1:0] a;
    logic [2:0]    sz;
    logic [32:0]   last;
    logic          oor, mis, ill, fault;
    logic [2:0]    new_flags;
    logic [7:0]    b0, b1, b2, b3;
    logic [31:0]   ext;
    always_comb begin
        a    = DMAddress[AW-1:0];
        sz   = DMCtrl[1:0] == 2'b01 ? 3'd2 : DMCtrl[1:0] == 2'b10 ? 3'd4 : 3'd1;
        last = {1'b0, DMAddress} + 33'(sz) - 33'd1;
        oor  = last >= 33'(DEPTH_BYTES);
        mis  = (DMCtrl[1:0] == 2'b01 && DMAddress[0]) || (DMCtrl[1:0] == 2'b10 && DMAddress[1:0] != 2'b00);
        // store rules are stricter, so either enable can raise the illegal-size flag
        ill  = (DMWr && (DMCtrl[2] || DMCtrl[1:0] == 2'b11)) ||
               (DMRd && (DMCtrl == 3'b011 || DMCtrl[2:1] == 2'b11));
        new_flags = (DMWr || DMRd) ? {ill, oor, mis} : 3'b000;
        fault = |new_flags;
        b0 = mem[a];
        b1 = mem[a + AW'(1)];
        b2 = mem[a + AW'(2)];
        b3 = mem[a + AW'(3)];
        ext = DMCtrl == 3'b000 ? {{24{b0[7]}}, b0} :
              DMCtrl == 3'b001 ? {{16{b1[7]}}, b1, b0} :
              DMCtrl == 3'b010 ? {b3, b2, b1, b0} :
              DMCtrl == 3'b100 ? {24'd0, b0} :
              DMCtrl == 3'b101 ? {16'd0, b1, b0} : 32'd0;
        DMDataRd = (DMRd && !fault) ? ext : 32'd0;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_BYTES; i++) mem[i] <= 8'h00;
            DMFaultFlags <= 3'b000;
            DMFaultAddr  <= 32'd0;
        end else begin
            if (DMWr && !fault) begin
                mem[a] <= DMDataWr[7:0];
                if (sz >= 3'd2) mem[a + AW'(1)] <= DMDataWr[15:8];
                if (sz == 3'd4) begin
                    mem[a + AW'(2)] <= DMDataWr[23:16];
                    mem[a + AW'(3)] <= DMDataWr[31:24];
                end
            end
            if (fault) begin
                DMFaultFlags <= DMFaultFlags | new_flags;
                if (DMFaultFlags == 3'b000) DMFaultAddr <= DMAddress;
            end
        end
    end
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed load/store, fault and reset checks for data_memory
module tb_data_memory;
    localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] DMAddress = '0, DMDataWr = '0;
    logic        DMWr = 1'b0, DMRd = 1'b0;
    logic [2:0]  DMCtrl = W;
    logic [31:0] DMDataRd, DMFaultAddr;
    logic [2:0]  DMFaultFlags;
    int tests = 0, fails = 0;

    data_memory #(.DEPTH_BYTES(1024)) dut (
        .clk(clk), .reset(reset), .DMAddress(DMAddress), .DMDataWr(DMDataWr),
        .DMWr(DMWr), .DMRd(DMRd), .DMCtrl(DMCtrl), .DMDataRd(DMDataRd),
        .DMFaultFlags(DMFaultFlags), .DMFaultAddr(DMFaultAddr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set(input logic wr, input logic rd, input logic [2:0] ctrl,
                       input logic [31:0] addr, input logic [31:0] data);
        DMWr = wr; DMRd = rd; DMCtrl = ctrl; DMAddress = addr; DMDataWr = data;
        #2;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic st(input logic [2:0] ctrl, input logic [31:0] addr, input logic [31:0] data);
        set(1'b1, 1'b0, ctrl, addr, data);
        step();
        set(1'b0, 1'b0, W, 32'd0, 32'd0);
    endtask

    task automatic ld(input string tag, input logic [2:0] ctrl, input logic [31:0] addr,
                      input logic [31:0] exp);
        set(1'b0, 1'b1, ctrl, addr, 32'd0);
        check(tag, DMDataRd, exp);
        step();
        set(1'b0, 1'b0, W, 32'd0, 32'd0);
    endtask

    task automatic do_reset;
        set(1'b0, 1'b0, W, 32'd0, 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        step();
        do_reset();
        // reset state
        ld("rst_lw0", W, 32'h0, 32'h0);
        check("rst_flags", 32'(DMFaultFlags), 32'h0);
        check("rst_faddr", DMFaultAddr, 32'h0);
        // access sizes and extension
        st(W, 32'h10, 32'h8000_80F0);
        ld("lw10", W, 32'h10, 32'h8000_80F0);
        ld("lb10", B, 32'h10, 32'hFFFF_FFF0);
        ld("lbu10", BU, 32'h10, 32'h0000_00F0);
        ld("lh12", H, 32'h12, 32'hFFFF_8000);
        ld("lhu12", HU, 32'h12, 32'h0000_8000);
        ld("lb13", B, 32'h13, 32'hFFFF_FF80);
        // byte-lane merge
        st(W, 32'h20, 32'h1122_3344);
        st(B, 32'h21, 32'h0000_00AA);
        st(H, 32'h22, 32'h0000_BBCC);
        ld("merge", W, 32'h20, 32'hBBCC_AA44);
        check("noflag_merge", 32'(DMFaultFlags), 32'h0);
        // misaligned store leaves memory untouched
        st(W, 32'h30, 32'hCAFE_F00D);
        st(W, 32'h34, 32'h0102_0304);
        st(W, 32'h31, 32'hDEAD_BEEF);
        check("mis_flags", 32'(DMFaultFlags), 32'h1);
        check("mis_faddr", DMFaultAddr, 32'h31);
        ld("mis_keep30", W, 32'h30, 32'hCAFE_F00D);
        ld("mis_keep34", W, 32'h34, 32'h0102_0304);
        ld("lh33", H, 32'h33, 32'h0);
        check("lh33_flags", 32'(DMFaultFlags), 32'h1);
        check("lh33_faddr", DMFaultAddr, 32'h31);
        // top-of-memory boundary, range and illegal size
        do_reset();
        check("rst2_flags", 32'(DMFaultFlags), 32'h0);
        st(W, 32'h3FC, 32'h1234_5678);
        ld("lw3fc", W, 32'h3FC, 32'h1234_5678);
        ld("lh3fe", H, 32'h3FE, 32'h0000_1234);
        ld("lb3ff", B, 32'h3FF, 32'h0000_0012);
        check("edge_noflag", 32'(DMFaultFlags), 32'h0);
        ld("lw3fe", W, 32'h3FE, 32'h0);
        check("oor_flags", 32'(DMFaultFlags), 32'h3);
        check("oor_faddr", DMFaultAddr, 32'h3FE);
        ld("lw_oor_wrap", W, 32'hFFFF_FFFC, 32'h0);
        st(W, 32'h40, 32'h0BAD_BEEF);
        st(BU, 32'h40, 32'h0000_0099);
        check("ill_flags", 32'(DMFaultFlags), 32'h7);
        check("ill_faddr", DMFaultAddr, 32'h3FE);
        ld("ill_keep40", W, 32'h40, 32'h0BAD_BEEF);
        // read-before-write
        st(W, 32'h50, 32'h55);
        set(1'b1, 1'b1, W, 32'h50, 32'h66);
        check("rbw_old", DMDataRd, 32'h55);
        step();
        ld("rbw_new", W, 32'h50, 32'h66);
        // mid-cycle reset during a pending store
        set(1'b1, 1'b1, W, 32'h50, 32'h77);
        check("pre_rst", DMDataRd, 32'h66);
        reset = 1'b1;
        #1;
        check("async_rst", DMDataRd, 32'h0);
        step();
        set(1'b0, 1'b1, W, 32'h50, 32'h0);
        reset = 1'b0;
        #1;
        check("rst_drop_rd", DMDataRd, 32'h0);
        step();
        ld("rst_drop_next", W, 32'h50, 32'h0);
        check("rst3_flags", 32'(DMFaultFlags), 32'h0);
        check("rst3_faddr", DMFaultAddr, 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/data_memory.md
# data_memory

Byte-addressable data memory for the MEM stage of the segmented processor. It performs RV32I-style loads and stores: sub-word loads are sign- or zero-extended, and stores write only the addressed byte lanes. Load data is presented combinationally so the MEM/WB output register captures it on the falling edge of `clk`. Faulting accesses are suppressed and recorded in sticky status registers for debug.

## Interface
- `DEPTH_BYTES`, default 1024: storage size in bytes. Must be a power of two and at least 4.
- `clk`  in  1: clock. Stores commit on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `DMAddress`  in  32: byte address from the ALU result.
- `DMDataWr`  in  32: store data from rs2. Low bytes are used for SB/SH.
- `DMWr`  in  1: store enable.
- `DMRd`  in  1: load enable.
- `DMCtrl`  in  3: access size, as funct3. 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `DMDataRd`  out  32: load result, combinational.
- `DMFaultFlags`  out  3: sticky fault flags. Bit0 misaligned, bit1 out-of-range, bit2 illegal size.
- `DMFaultAddr`  out  32: `DMAddress` of the first faulting access since reset.

## Operation
- **Storage:** `DEPTH_BYTES` × 8-bit array, little-endian. Byte `A` holds bits [7:0] of a word at `A`, and byte `A+3` holds bits [31:24].
- **Access active:** an access is active when `DMWr | DMRd`. Fault checks apply only to active accesses.
- **Fault conditions** (any combination may occur together):
  - Out-of-range: `DMAddress + size − 1 >= DEPTH_BYTES`, where size is 1, 2 or 4. Computed with 33-bit arithmetic, so there is no wrap.
  - Misaligned: H/HU/SH with `addr[0]=1`, or W/SW with `addr[1:0]!=0`.
  - Illegal size, loads: `DMCtrl` ∈ {011, 110, 111}.
  - Illegal size, stores: any `DMCtrl` other than 000/001/010.
- **Loads:**
  - `DMDataRd` = addressed bytes, extended to 32 bits.
  - B and H are sign-extended from bit 7 and bit 15 respectively.
  - BU and HU are zero-extended.
  - `DMDataRd` = 0 when `DMRd=0` or the load faults.
- **Stores:**
  - On the rising edge with `DMWr=1` and no fault, write 1, 2 or 4 bytes from `DMDataWr[7:0]`, `[15:0]` or `[31:0]`.
  - A faulting store writes nothing.
- **Fault recording**, on the rising edge when an active access faults:
  - `DMFaultFlags <= DMFaultFlags | new_flags`.
  - `DMFaultAddr <= DMAddress`, but only if `DMFaultFlags` was 000 before that edge.
  - Flags clear only on reset.
- **`DMWr` and `DMRd` both high:** the load sees the pre-store contents (read-before-write). The store commits at the edge. One fault evaluation uses the store size rules; illegal-size is flagged if either rule is violated.
- **Reset** (asynchronous, takes effect immediately, may occur mid-cycle):
  - All storage bytes = 0x00.
  - `DMFaultFlags` = 000, `DMFaultAddr` = 0.
  - `DMDataRd` = 0, because contents are zero.
  - A store whose edge coincides with asserted reset is discarded.

## Timing
- **Load latency:** zero cycles. `DMDataRd` is valid within the same cycle and must settle before the falling edge, where the MEM/WB register samples it.
- **Store latency:** the written data is visible to a load starting the cycle after the rising edge.
- **Fault status latency:** `DMFaultFlags` and `DMFaultAddr` update on the rising edge that ends the faulting access. They are visible the next cycle.
- **No handshake:** there is no stall or wait state. Every access completes in one cycle.
- **Reset release:** the first rising edge with `reset=0` may commit a store.

## Test plan
1. **Reset:** assert reset, then release. Load W at 0x0 → `DMDataRd`=0x00000000, `DMFaultFlags`=000, `DMFaultAddr`=0.
2. **Store/load sizes:**
   - SW 0x8000_80F0 to 0x10.
   - Loads from 0x10: W → 0x800080F0, B → 0xFFFFFFF0, BU → 0x000000F0.
   - Loads from 0x12: H → 0xFFFF8000, HU → 0x00008000.
   - LB 0x13 → 0xFFFFFF80.
3. **Byte-lane merge:** SW 0x11223344 @0x20, SB 0xAA @0x21, SH 0xBBCC @0x22. LW 0x20 → 0xBBCCAA44.
4. **Misaligned store:**
   - SW 0xDEADBEEF @0x31 → memory 0x30..0x37 unchanged; the next cycle `DMFaultFlags`=001, `DMFaultAddr`=0x31.
   - A subsequent LH @0x33 → `DMDataRd`=0; flags stay 001; `DMFaultAddr` stays 0x31.
5. **Range and illegal size** (`DEPTH_BYTES`=1024):
   - LW @0x3FE → `DMDataRd`=0; flags become 011.
   - SW with `DMCtrl`=100 @0x40 → no write; flags become 111; `DMFaultAddr` still 0x3FE.
   - LW @0x3FC after SW 0x12345678 @0x3FC → 0x12345678, with no new flag.
6. **Simultaneous events and mid-cycle reset:**
   - With word 0x55 stored at 0x50, drive `DMWr=DMRd=1`, SW 0x66 @0x50, in one cycle → `DMDataRd`=0x55 that cycle, 0x66 the next.
   - Assert reset mid-cycle during a pending SW → `DMDataRd` drops to 0 immediately, and the store never lands after release.
